// File: rtl/usb_pixel_unpacker_pkg.sv
// ============================================================================
// Module : usb_pixel_unpacker_pkg
// Brief  : Shared state encoding and packet constants for the pixel unpacker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_pixel_unpacker_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         HDR_BYTES         = 6;

    // Header states are numbered by the count of header bytes already taken,
    // so the first data state sits exactly at HDR_BYTES.
    typedef enum logic [3:0] {
        ST_HUNT = 4'd0,
        ST_ADR0 = 4'd1,
        ST_ADR1 = 4'd2,
        ST_ADR2 = 4'd3,
        ST_LEN0 = 4'd4,
        ST_LEN1 = 4'd5,
        ST_DLO  = 4'(HDR_BYTES),
        ST_DHI  = 4'(HDR_BYTES + 1),
        ST_WREQ = 4'(HDR_BYTES + 2),
        ST_WDAT = 4'(HDR_BYTES + 3)
    } state_t;

    function automatic logic accepts_byte(input state_t s);
        return !((s == ST_WREQ) || (s == ST_WDAT));
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_pixel_unpacker.sv
// ============================================================================
// Module : usb_pixel_unpacker
// Brief  : Parses sync/address/length packets from the FTDI byte stream and
//          issues single-word RGB565 writes to the SDRAM controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_pixel_unpacker
    import usb_pixel_unpacker_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         AW        = 25
) (
    input  logic          mem_clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          mem_idle,
    output logic          mem_wr_req,
    output logic [AW-1:0] mem_wr_addr,
    output logic [15:0]   mem_wr_data,
    input  logic          mem_ack,
    input  logic          mem_data_next,
    output logic          busy,
    output logic [7:0]    sync_err,
    output logic          pkt_done
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_hdr_lo;
    logic [7:0]  r_len_lo;
    logic [7:0]  r_lo_byte;
    logic [15:0] r_remaining;
    logic        r_early;
    logic        w_hs;
    logic        w_consume;

    assign w_hs      = in_valid & in_ready;
    // A data_next seen together with the ack is remembered so WDAT can leave at once.
    assign w_consume = (r_state == ST_WDAT) & (r_early | mem_data_next);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HUNT: if (w_hs && (in_data == SYNC_BYTE)) w_next = ST_ADR0;
            ST_ADR0: if (w_hs) w_next = ST_ADR1;
            ST_ADR1: if (w_hs) w_next = ST_ADR2;
            ST_ADR2: if (w_hs) w_next = ST_LEN0;
            ST_LEN0: if (w_hs) w_next = ST_LEN1;
            ST_LEN1: begin
                if (w_hs) begin
                    w_next = ({in_data, r_len_lo} == 16'd0) ? ST_HUNT : ST_DLO;
                end
            end
            ST_DLO:  if (w_hs) w_next = ST_DHI;
            ST_DHI:  if (w_hs) w_next = ST_WREQ;
            ST_WREQ: if (mem_wr_req && mem_ack) w_next = ST_WDAT;
            ST_WDAT: begin
                if (w_consume) begin
                    w_next = (r_remaining == 16'd1) ? ST_HUNT : ST_DLO;
                end
            end
            default: w_next = ST_HUNT;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            r_state     <= ST_HUNT;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            sync_err    <= '0;
            pkt_done    <= 1'b0;
            r_hdr_lo    <= '0;
            r_len_lo    <= '0;
            r_lo_byte   <= '0;
            r_remaining <= '0;
            r_early     <= 1'b0;
        end else begin
            r_state  <= w_next;
            in_ready <= accepts_byte(w_next);
            busy     <= (w_next != ST_HUNT);
            pkt_done <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (w_hs && (in_data != SYNC_BYTE) && (sync_err != 8'hFF)) begin
                        sync_err <= sync_err + 8'd1;
                    end
                end
                ST_ADR0: if (w_hs) r_hdr_lo[7:0]  <= in_data;
                ST_ADR1: if (w_hs) r_hdr_lo[15:8] <= in_data;
                // Header address is 24 bits; resize drops or zero-fills to AW.
                ST_ADR2: if (w_hs) mem_wr_addr <= AW'({in_data, r_hdr_lo});
                ST_LEN0: if (w_hs) r_len_lo <= in_data;
                ST_LEN1: if (w_hs) r_remaining <= {in_data, r_len_lo};
                ST_DLO:  if (w_hs) r_lo_byte <= in_data;
                ST_DHI: begin
                    if (w_hs) begin
                        mem_wr_data <= {in_data, r_lo_byte};
                        mem_wr_req  <= mem_idle;
                    end
                end
                ST_WREQ: begin
                    if (!mem_wr_req) begin
                        mem_wr_req <= mem_idle;
                    end else if (mem_ack) begin
                        mem_wr_req <= 1'b0;
                        r_early    <= mem_data_next;
                    end
                end
                ST_WDAT: begin
                    if (w_consume) begin
                        mem_wr_addr <= mem_wr_addr + AW'(1);
                        r_remaining <= r_remaining - 16'd1;
                        r_early     <= 1'b0;
                        pkt_done    <= (r_remaining == 16'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usb_pixel_unpacker.sv
// ============================================================================
// Module : tb_usb_pixel_unpacker
// Brief  : Self-checking bench with a packet-level write scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_pixel_unpacker;
    import usb_pixel_unpacker_pkg::*;

    localparam int AW = 17;

    logic          mem_clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_idle = 1'b1;
    logic          mem_wr_req;
    logic [AW-1:0] mem_wr_addr;
    logic [15:0]   mem_wr_data;
    logic          mem_ack = 1'b0;
    logic          mem_data_next = 1'b0;
    logic          busy;
    logic [7:0]    sync_err;
    logic          pkt_done;

    usb_pixel_unpacker #(.SYNC_BYTE(8'hA5), .AW(AW)) dut (
        .mem_clk      (mem_clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_idle     (mem_idle),
        .mem_wr_req   (mem_wr_req),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_ack      (mem_ack),
        .mem_data_next(mem_data_next),
        .busy         (busy),
        .sync_err     (sync_err),
        .pkt_done     (pkt_done)
    );

    always #5 mem_clk = ~mem_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int obs_addr[$];
    int obs_data[$];
    int exp_addr[$];
    int exp_data[$];
    int dir_words[$];
    int exp_sync = 0;
    int exp_done = 0;
    int pkt_cnt  = 0;
    bit idle_rand = 1'b0;
    bit rand_resp = 1'b0;
    bit hold_next = 1'b0;
    bit lat_chk   = 1'b0;
    int ack_fix   = 2;
    int next_fix  = 2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Memory controller model: acks after a delay, then consumes the data.
    int   phase = 0;
    int   wait_cnt = 0;
    int   ack_wait = 0;
    int   nd_rem = 0;
    logic [15:0] held_data;
    initial begin
        forever begin
            @(negedge mem_clk);
            mem_ack = 1'b0;
            mem_data_next = 1'b0;
            if (rst) begin
                phase = 0;
                wait_cnt = 0;
            end else if (phase == 1) begin
                if (!hold_next) begin
                    if (nd_rem == 0) begin
                        mem_data_next = 1'b1;
                        check("wdat_data_hold", mem_wr_data, held_data);
                        phase = 0;
                    end else begin
                        nd_rem--;
                    end
                end
            end else if (mem_wr_req) begin
                if (wait_cnt == 0) ack_wait = rand_resp ? int'($urandom_range(0, 3)) : ack_fix;
                if (wait_cnt >= ack_wait) begin
                    int nd;
                    mem_ack = 1'b1;
                    obs_addr.push_back(int'(mem_wr_addr));
                    obs_data.push_back(int'(mem_wr_data));
                    held_data = mem_wr_data;
                    nd = rand_resp ? int'($urandom_range(0, 2)) : next_fix;
                    if (nd == 0 && !hold_next) begin
                        mem_data_next = 1'b1;
                    end else begin
                        phase = 1;
                        nd_rem = (nd > 0) ? nd - 1 : 0;
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge mem_clk);
            if (idle_rand) mem_idle = ($urandom_range(0, 3) != 0);
        end
    end

    // Request protocol monitor and pkt_done pulse counter.
    initial begin
        logic idle_e, ack_e, req_e, rst_e;
        forever begin
            @(negedge mem_clk);
            #4;
            idle_e = mem_idle; ack_e = mem_ack; req_e = mem_wr_req; rst_e = rst;
            @(posedge mem_clk);
            #1;
            if (!rst_e) begin
                if (!req_e && mem_wr_req) check("req_rise_needs_idle", idle_e, 1'b1);
                if (req_e && !mem_wr_req) check("req_held_until_ack", ack_e, 1'b1);
                if (pkt_done) pkt_cnt++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge mem_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (rand_resp) cyc($urandom_range(0, 1));
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 500) begin
            cyc(1);
            n++;
        end
        if (n >= 500) check("in_ready_timeout", in_ready, 1'b1);
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [23:0] a, input logic [15:0] n);
        send_byte(8'hA5);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(a[23:16]);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic send_packet(input logic [23:0] a, input int n);
        logic [15:0] w;
        send_hdr(a, 16'(n));
        if (n > 0) exp_done++;
        for (int i = 0; i < n; i++) begin
            if (dir_words.size() > 0) w = 16'(dir_words.pop_front());
            else w = 16'($urandom_range(0, 65535));
            exp_addr.push_back(((int'(a) % (1 << AW)) + i) % (1 << AW));
            exp_data.push_back(int'(w));
            send_byte(w[7:0]);
            send_byte(w[15:8]);
            if (lat_chk) check("req_latency", mem_wr_req, 1'b1);
        end
    endtask

    task automatic send_garbage(input int k);
        logic [7:0] b;
        for (int i = 0; i < k; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b);
        end
        exp_sync = (exp_sync + k > 255) ? 255 : exp_sync + k;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || obs_addr.size() < exp_addr.size()) && n < 3000) begin
            cyc(1);
            n++;
        end
        cyc(2);
        check("idle_after_pkt", busy, 1'b0);
    endtask

    task automatic check_writes(input string tag);
        check($sformatf("%s_nwrites", tag), obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
        end
        obs_addr.delete(); obs_data.delete();
        exp_addr.delete(); exp_data.delete();
        check($sformatf("%s_pkt_done", tag), pkt_cnt, exp_done);
        check($sformatf("%s_sync_err", tag), sync_err, exp_sync);
    endtask

    initial begin
        int n;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_req", mem_wr_req, 1'b0);
        check("rst_addr", mem_wr_addr, '0);
        check("rst_data", mem_wr_data, 16'h0);
        check("rst_sync_err", sync_err, 8'h00);
        check("rst_pkt_done", pkt_done, 1'b0);

        // Nominal three-word packet
        lat_chk = 1'b1;
        dir_words = '{32'h2211, 32'h4433, 32'h6655};
        send_packet(24'h001000, 3);
        lat_chk = 1'b0;
        wait_done();
        check_writes("nominal");

        // Sync hunt
        send_byte(8'h00);
        send_byte(8'hFF);
        exp_sync += 2;
        send_packet(24'h000123, 1);
        wait_done();
        check_writes("hunt");

        // Read priority
        mem_idle = 1'b0;
        send_packet(24'h000200, 1);
        for (int i = 0; i < 20; i++) begin
            check("rdprio_req_low", mem_wr_req, 1'b0);
            check("rdprio_ready_low", in_ready, 1'b0);
            cyc(1);
        end
        @(negedge mem_clk);
        mem_idle = 1'b1;
        @(posedge mem_clk);
        #1;
        check("rdprio_req_rise", mem_wr_req, 1'b1);
        wait_done();
        check_writes("rdprio");

        // Address wrap, same-cycle ack and data_next
        next_fix = 0;
        send_packet(24'h01FFFF, 2);
        wait_done();
        check_writes("wrap");
        next_fix = 2;

        // Zero length
        send_packet(24'h123456, 0);
        cyc(3);
        check("zero_busy", busy, 1'b0);
        check("zero_ready", in_ready, 1'b1);
        check("zero_req", mem_wr_req, 1'b0);
        check_writes("zero");

        // Reset while waiting in WDAT
        hold_next = 1'b1;
        send_hdr(24'h000040, 16'd2);
        send_byte(8'h12);
        send_byte(8'h34);
        n = 0;
        while (obs_addr.size() < 1 && n < 200) begin
            cyc(1);
            n++;
        end
        cyc(2);
        check("wdat_stall_busy", busy, 1'b1);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        hold_next = 1'b0;
        cyc(1);
        exp_sync = 0;
        check("midrst_req", mem_wr_req, 1'b0);
        check("midrst_sync_err", sync_err, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", in_ready, 1'b1);
        obs_addr.delete(); obs_data.delete();
        send_packet(24'h000500, 2);
        wait_done();
        check_writes("after_rst");

        // Randomized traffic
        rand_resp = 1'b1;
        idle_rand = 1'b1;
        for (int p = 0; p < 12; p++) begin
            send_garbage($urandom_range(0, 3));
            send_packet(24'($urandom), $urandom_range(0, 6));
        end
        wait_done();
        check_writes("random");
        rand_resp = 1'b0;
        idle_rand = 1'b0;
        @(negedge mem_clk);
        mem_idle = 1'b1;
        cyc(1);

        // sync_err saturation
        send_garbage(260);
        cyc(2);
        check("sync_err_sat", sync_err, exp_sync);
        check("sync_err_sat_val", sync_err, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL global_timeout got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
